mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 34 +++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the shared memory port arbiter.
// Handshake: a requester holds req/addr/wdata/we stable until its one-cycle ready pulse.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output if_rdata, if_ready, d_rdata, d_ready, m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready, m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one fixed-latency memory port.
// One access in flight at a time: IDLE -> ACCESS -> WAIT (LAT cycles) -> DONE.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 2,
    parameter int MAX_D  = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    mem_port_arbiter_if.slave   port_io,
    output logic [1:0]          state_o,
    output logic [3:0]          dcnt_o
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [3:0] LAT_C   = 4'(LAT);
    localparam logic [3:0] MAX_D_C = 4'(MAX_D);

    state_e            state_q;
    logic [3:0]        dcnt_q, dcnt_d;
    logic [3:0]        wcnt_q;
    logic              fetch_q;
    logic              we_q;
    logic              m_en_q, m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
    logic              if_ready_q, d_ready_q;

    logic fetch_turn, grant_d, grant_f;

    // Data has priority until it has starved a waiting fetch MAX_D times in a row.
    always_comb begin
        fetch_turn = port_io.if_req && (dcnt_q == MAX_D_C);
        grant_d    = port_io.d_req && !fetch_turn;
        grant_f    = port_io.if_req && !grant_d;
        dcnt_d     = dcnt_q;
        if (grant_d) begin
            if (!port_io.if_req)         dcnt_d = 4'd0;
            else if (dcnt_q != MAX_D_C)  dcnt_d = dcnt_q + 4'd1;
        end else if (grant_f) begin
            dcnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            dcnt_q     <= 4'd0;
            wcnt_q     <= 4'd0;
            fetch_q    <= 1'b0;
            we_q       <= 1'b0;
            m_en_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d || grant_f) begin
                        fetch_q  <= grant_f;
                        we_q     <= grant_d && port_io.d_we;
                        m_en_q   <= 1'b1;
                        m_we_q   <= grant_d && port_io.d_we;
                        m_addr_q <= grant_d ? port_io.d_addr : port_io.if_addr;
                        if (grant_d) m_wdata_q <= port_io.d_wdata;
                        dcnt_q   <= dcnt_d;
                        state_q  <= ACCESS;
                    end
                end
                ACCESS: begin
                    m_en_q  <= 1'b0;
                    m_we_q  <= 1'b0;
                    wcnt_q  <= LAT_C;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // Last wait cycle is the one where memory presents read data.
                    if (wcnt_q == 4'd1) begin
                        wcnt_q  <= 4'd0;
                        state_q <= DONE;
                        if (fetch_q) begin
                            if_rdata_q <= port_io.m_rdata;
                            if_ready_q <= 1'b1;
                        end else begin
                            if (!we_q) d_rdata_q <= port_io.m_rdata;
                            d_ready_q <= 1'b1;
                        end
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                DONE: begin
                    if_ready_q <= 1'b0;
                    d_ready_q  <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign port_io.m_en     = m_en_q;
    assign port_io.m_we     = m_we_q;
    assign port_io.m_addr   = m_addr_q;
    assign port_io.m_wdata  = m_wdata_q;
    assign port_io.if_rdata = if_rdata_q;
    assign port_io.if_ready = if_ready_q;
    assign port_io.d_rdata  = d_rdata_q;
    assign port_io.d_ready  = d_ready_q;
    assign state_o          = state_q;
    assign dcnt_o           = dcnt_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: LAT=2/MAX_D=4 instance fully checked, LAT=1 instance for latency.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  logic [1:0] state0, state1;
  logic [3:0] dcnt0, dcnt1;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(2), .MAX_D(4)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .port_io(bus0.slave), .state_o(state0), .dcnt_o(dcnt0)
  );
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1), .MAX_D(4)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .port_io(bus1.slave), .state_o(state1), .dcnt_o(dcnt1)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return a ^ 32'h5A5A0000 ^ {a[7:0], 24'h0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // memory models: read data valid only in the cycle LAT after m_en, garbage otherwise
  logic [15:0] vld0, vld1;
  logic [31:0] dat0[16];
  logic [31:0] dat1[16];
  always @(posedge clk) begin
    if (!rst_n) begin
      vld0 <= '0;
      vld1 <= '0;
    end else begin
      vld0 <= {vld0[14:0], bus0.m_en & ~bus0.m_we};
      vld1 <= {vld1[14:0], bus1.m_en & ~bus1.m_we};
      for (int i = 15; i > 0; i--) begin
        dat0[i] <= dat0[i-1];
        dat1[i] <= dat1[i-1];
      end
      dat0[0] <= mem_word(bus0.m_addr);
      dat1[0] <= mem_word(bus1.m_addr);
    end
  end
  assign bus0.m_rdata = vld0[1] ? dat0[1] : 32'hBAD0BAD0;
  assign bus1.m_rdata = vld1[0] ? dat1[0] : 32'hBAD0BAD0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        fetch;
    logic [3:0]  dcnt;
    int          gap;
  } acc_t;

  acc_t        acc_q[$];
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_d_q[$];
  logic [31:0] exp_last_d = 32'h0;

  task automatic push_acc(input logic [31:0] a, input logic we, input logic [31:0] wd,
                          input logic f, input logic [3:0] dc, input int gap);
    acc_t e;
    e.addr = a; e.we = we; e.wdata = wd; e.fetch = f; e.dcnt = dc; e.gap = gap;
    acc_q.push_back(e);
  endtask

  // monitor: pops expectations whenever the DUT presents an access or a ready pulse
  bit   pend = 1'b0;
  bit   pend_fetch = 1'b0;
  int   pend_t = 0;
  int   last_en = -100;
  acc_t me;
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (bus0.if_ready && bus0.d_ready) chk("ready_exclusive", 32'(bus0.d_ready), 32'd0);
      if (bus0.m_we && !bus0.m_en) chk("m_we_outside_access", 32'(bus0.m_we), 32'd0);
      if (bus0.m_en) begin
        if (acc_q.size() == 0) begin
          chk("unexpected_access", 32'(bus0.m_en), 32'd0);
        end else begin
          me = acc_q.pop_front();
          chk("m_addr", bus0.m_addr, me.addr);
          chk("m_we", 32'(bus0.m_we), 32'(me.we));
          if (me.we) chk("m_wdata", bus0.m_wdata, me.wdata);
          chk("dcnt", 32'(dcnt0), 32'(me.dcnt));
          if (me.gap >= 0) chk("grant_gap", 32'(cyc - last_en), 32'(me.gap));
          last_en    = cyc;
          pend       = 1'b1;
          pend_fetch = me.fetch;
          pend_t     = cyc;
        end
      end
      if (bus0.if_ready || bus0.d_ready) begin
        if (!pend) begin
          chk("unexpected_ready", 32'(pend), 32'd1);
        end else begin
          chk("ready_port", 32'(bus0.if_ready), 32'(pend_fetch));
          chk("ready_latency", 32'(cyc - pend_t), 32'd3);
          if (bus0.if_ready) begin
            if (exp_if_q.size() == 0) chk("if_q_underflow", 32'(exp_if_q.size()), 32'd1);
            else chk("if_rdata", bus0.if_rdata, exp_if_q.pop_front());
          end else begin
            if (exp_d_q.size() == 0) chk("d_q_underflow", 32'(exp_d_q.size()), 32'd1);
            else chk("d_rdata", bus0.d_rdata, exp_d_q.pop_front());
          end
          pend = 1'b0;
        end
      end
    end
  end

  // data-port stimulus table
  logic [31:0] t_addr[10] = '{32'h20, 32'h40, 32'h50, 32'h100, 32'h104,
                              32'h108, 32'h10C, 32'h110, 32'h114, 32'h70};
  logic        t_we[10]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [31:0] t_wd[10]   = '{32'h0, 32'h12345678, 32'h0, 32'h0, 32'hA1,
                              32'h0, 32'hB2, 32'h0, 32'h0, 32'h0};

  task automatic wait_ready(input bit fetch, input string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(posedge clk); #1;
      seen = fetch ? bus0.if_ready : bus0.d_ready;
    end
    chk(nm, 32'(seen), 32'd1);
  endtask

  task automatic fetch_op(input logic [31:0] a);
    bus0.if_addr = a;
    bus0.if_req  = 1'b1;
    exp_if_q.push_back(mem_word(a));
    wait_ready(1'b1, "if_ready_seen");
    bus0.if_req = 1'b0;
  endtask

  // d_req stays high across consecutive operations; only addr/we/wdata change after each ready
  task automatic data_seq(input int first, input int n);
    for (int k = first; k < first + n; k++) begin
      bus0.d_addr  = t_addr[k];
      bus0.d_we    = t_we[k];
      bus0.d_wdata = t_wd[k];
      bus0.d_req   = 1'b1;
      if (t_we[k]) begin
        exp_d_q.push_back(exp_last_d);
      end else begin
        exp_last_d = mem_word(t_addr[k]);
        exp_d_q.push_back(exp_last_d);
      end
      wait_ready(1'b0, "d_ready_seen");
    end
    bus0.d_req = 1'b0;
  endtask

  int          t_en1, t_rdy1;
  logic [31:0] rd1;
  bit          reached;

  initial begin
    bus0.if_req = 0; bus0.if_addr = 0; bus0.d_req = 0; bus0.d_we = 0; bus0.d_addr = 0; bus0.d_wdata = 0;
    bus1.if_req = 0; bus1.if_addr = 0; bus1.d_req = 0; bus1.d_we = 0; bus1.d_addr = 0; bus1.d_wdata = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state0), 32'd0);
    chk("rst_m_en", 32'(bus0.m_en), 32'd0);
    chk("rst_m_we", 32'(bus0.m_we), 32'd0);
    chk("rst_m_addr", bus0.m_addr, 32'd0);
    chk("rst_m_wdata", bus0.m_wdata, 32'd0);
    chk("rst_if_ready", 32'(bus0.if_ready), 32'd0);
    chk("rst_d_ready", 32'(bus0.d_ready), 32'd0);
    chk("rst_if_rdata", bus0.if_rdata, 32'd0);
    chk("rst_d_rdata", bus0.d_rdata, 32'd0);
    chk("rst_dcnt", 32'(dcnt0), 32'd0);
    chk("rst_state_lat1", 32'(state1), 32'd0);

    // single fetch granted in the first cycle after release
    push_acc(32'h10, 1'b0, 32'h0, 1'b1, 4'd0, -1);
    rst_n = 1'b1;
    fork
      fetch_op(32'h10);
      begin
        @(posedge clk); #1;
        chk("first_grant_access", 32'(state0), 32'd1);
      end
    join

    // load then store: store leaves d_rdata at the loaded value
    push_acc(32'h20, 1'b0, 32'h0, 1'b0, 4'd0, -1);
    push_acc(32'h40, 1'b1, 32'h12345678, 1'b0, 4'd0, 5);
    data_seq(0, 2);

    // simultaneous requests: data first, fetch five cycles later
    push_acc(32'h50, 1'b0, 32'h0, 1'b0, 4'd1, -1);
    push_acc(32'h30, 1'b0, 32'h0, 1'b1, 4'd0, 5);
    fork
      fetch_op(32'h30);
      data_seq(2, 1);
    join

    // starvation limit: four data grants, then the waiting fetch, then data resumes
    push_acc(32'h100, 1'b0, 32'h0,  1'b0, 4'd1, -1);
    push_acc(32'h104, 1'b1, 32'hA1, 1'b0, 4'd2, 5);
    push_acc(32'h108, 1'b0, 32'h0,  1'b0, 4'd3, 5);
    push_acc(32'h10C, 1'b1, 32'hB2, 1'b0, 4'd4, 5);
    push_acc(32'h80,  1'b0, 32'h0,  1'b1, 4'd0, 5);
    push_acc(32'h110, 1'b0, 32'h0,  1'b0, 4'd0, 5);
    push_acc(32'h114, 1'b0, 32'h0,  1'b0, 4'd0, 5);
    fork
      fetch_op(32'h80);
      data_seq(3, 6);
    join

    // reset during WAIT of a load abandons it
    push_acc(32'h60, 1'b0, 32'h0, 1'b0, 4'd0, -1);
    bus0.d_addr = 32'h60; bus0.d_we = 1'b0; bus0.d_req = 1'b1;
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      @(posedge clk); #1;
      reached = (state0 == 2'd2);
    end
    chk("reach_wait", 32'(reached), 32'd1);
    rst_n = 1'b0;
    bus0.d_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_last_d = 32'h0;
    chk("abort_state", 32'(state0), 32'd0);
    chk("abort_d_rdata", bus0.d_rdata, 32'd0);
    chk("abort_d_ready", 32'(bus0.d_ready), 32'd0);
    chk("abort_m_en", 32'(bus0.m_en), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    push_acc(32'h70, 1'b0, 32'h0, 1'b0, 4'd0, -1);
    data_seq(9, 1);

    // LAT=1 instance: load completes two cycles after its access
    bus1.d_addr = 32'h90; bus1.d_we = 1'b0; bus1.d_req = 1'b1;
    t_en1 = -100; t_rdy1 = -1; rd1 = 32'h0;
    for (int k = 0; k < 20 && t_rdy1 < 0; k++) begin
      @(posedge clk); #1;
      if (bus1.m_en) t_en1 = cyc;
      if (bus1.d_ready) begin
        t_rdy1 = cyc;
        rd1 = bus1.d_rdata;
      end
    end
    bus1.d_req = 1'b0;
    chk("lat1_ready_latency", 32'(t_rdy1 - t_en1), 32'd2);
    chk("lat1_d_rdata", rd1, mem_word(32'h90));

    repeat (10) @(posedge clk);
    chk("acc_q_drained", 32'(acc_q.size()), 32'd0);
    chk("if_q_drained", 32'(exp_if_q.size()), 32'd0);
    chk("d_q_drained", 32'(exp_d_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
